// File: rtl/rf_check_pkg.sv
// Shared types and constants for the register-file watch checker.
package rf_check_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Checker sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_PASS,
        ST_FAIL
    } state_t;

    // One check-table entry: wait for flag, then compare chk_reg against val
    typedef struct packed {
        logic [XLEN-1:0]       flag;
        logic [REG_ADDR_W-1:0] chk_reg;
        logic [XLEN-1:0]       val;
    } entry_t;

endpackage

// File: rtl/rf_shadow.sv
// Shadow copy of the architectural register file, fed by a snooped write port.
// Reads return registered contents only; x0 always reads as zero.
module rf_shadow
    import rf_check_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic [REG_ADDR_W-1:0] flag_addr,
    output logic [XLEN-1:0]       flag_data,
    input  logic [REG_ADDR_W-1:0] chk_addr,
    output logic [XLEN-1:0]       chk_data
);

    logic [XLEN-1:0] regs [32];

    // Capture snooped writes; x0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '{default: '0};
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign flag_data = (flag_addr == '0) ? '0 : regs[flag_addr];
    assign chk_data  = (chk_addr  == '0) ? '0 : regs[chk_addr];

endmodule

// File: rtl/rf_watch_checker.sv
// Register-file watch checker: walks a table of {flag, reg, val} entries,
// waiting for the flag register to hold each entry's flag and then checking
// the entry's register value. Reports pass, first mismatch, or timeout.
module rf_watch_checker
    import rf_check_pkg::*;
#(
    parameter int  NUM_CHECKS     = 4,
    parameter int  TIMEOUT_CYCLES = 100,
    parameter int  FLAG_REG       = 20,
    localparam int IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [XLEN-1:0]       cfg_flag,
    input  logic [REG_ADDR_W-1:0] cfg_reg,
    input  logic [XLEN-1:0]       cfg_val,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timed_out,
    output logic [IDX_W-1:0]      fail_idx,
    output logic [XLEN-1:0]       fail_got
);

    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_CHECKS - 1);
    localparam logic [CNT_W-1:0]      CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [REG_ADDR_W-1:0] FLAG_ADDR = REG_ADDR_W'(FLAG_REG);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    entry_t           table_q [NUM_CHECKS];
    entry_t           cur;
    logic             cfg_hit;
    logic [XLEN-1:0]  flag_data;
    logic [XLEN-1:0]  chk_data;

    rf_shadow u_shadow (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data),
        .flag_addr (FLAG_ADDR),
        .flag_data (flag_data),
        .chk_addr  (cur.chk_reg),
        .chk_data  (chk_data)
    );

    assign cur     = table_q[idx];
    assign cfg_hit = cfg_we && !busy && (int'(cfg_idx) < NUM_CHECKS);
    // Saturate so the counter cannot wrap if a match lands right at the limit
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // Check-table programming, locked out while a run is in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            table_q <= '{default: '0};
        end else if (cfg_hit) begin
            table_q[cfg_idx] <= '{flag: cfg_flag, chk_reg: cfg_reg, val: cfg_val};
        end
    end

    // Run sequencing with registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
            fail_idx  <= '0;
            fail_got  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start) begin
                        state     <= ST_WAIT;
                        idx       <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timed_out <= 1'b0;
                        fail_idx  <= '0;
                        fail_got  <= '0;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt_inc;
                    if (flag_data == cur.flag) begin
                        state <= ST_CHECK;
                    end else if (cnt >= CNT_LIMIT) begin
                        state     <= ST_FAIL;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        timed_out <= 1'b1;
                        fail_idx  <= idx;
                        fail_got  <= flag_data;
                    end
                end
                ST_CHECK: begin
                    // Timeout is only evaluated in WAIT, so a CHECK decision always wins
                    cnt <= cnt_inc;
                    if (chk_data != cur.val) begin
                        state    <= ST_FAIL;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        fail_idx <= idx;
                        fail_got <= chk_data;
                    end else if (idx == LAST_IDX) begin
                        state <= ST_PASS;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
                        idx   <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_watch_checker.sv
// Self-checking bench for rf_watch_checker: directed scenarios plus random
// traffic, every cycle compared against a behavioural model of the checker.
module tb_rf_watch_checker;

    localparam int NC = 3;
    localparam int TO = 100;
    localparam int FR = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [31:0] cfg_flag = '0;
    logic [4:0]  cfg_reg = '0;
    logic [31:0] cfg_val = '0;
    logic        start = 1'b0;
    logic        busy, done, pass, timed_out;
    logic [1:0]  fail_idx;
    logic [31:0] fail_got;

    rf_watch_checker #(
        .NUM_CHECKS     (NC),
        .TIMEOUT_CYCLES (TO),
        .FLAG_REG       (FR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_flag  (cfg_flag),
        .cfg_reg   (cfg_reg),
        .cfg_val   (cfg_val),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .timed_out (timed_out),
        .fail_idx  (fail_idx),
        .fail_got  (fail_got)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: register contents, table, and the progress of a run
    logic [31:0] m_rf [32];
    logic [31:0] m_flag [NC];
    logic [4:0]  m_reg [NC];
    logic [31:0] m_val [NC];
    bit          m_busy, m_waiting_done, m_done, m_pass, m_to;
    int          m_entry, m_elapsed, m_fidx;
    logic [31:0] m_fgot;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        for (int i = 0; i < NC; i++) begin
            m_flag[i] = '0; m_reg[i] = '0; m_val[i] = '0;
        end
        m_busy = 0; m_waiting_done = 0; m_done = 0; m_pass = 0; m_to = 0;
        m_entry = 0; m_elapsed = 0; m_fidx = 0; m_fgot = '0;
    endfunction

    function automatic void end_run(bit ok, bit tmo, bit failed, logic [31:0] seen);
        m_busy = 0;
        m_done = 1;
        m_pass = ok;
        m_to   = tmo;
        if (failed) begin
            m_fidx = m_entry;
            m_fgot = seen;
        end
    endfunction

    // Applies one clock edge worth of behaviour using pre-edge values
    function automatic void model_step();
        bit          was_busy;
        logic [31:0] seen;
        was_busy = m_busy;
        if (m_busy) begin
            if (!m_waiting_done) begin
                seen = m_rf[FR];
                if (seen == m_flag[m_entry]) m_waiting_done = 1;
                else if (m_elapsed >= TO - 1) end_run(0, 1, 1, seen);
            end else begin
                seen = m_rf[m_reg[m_entry]];
                if (seen != m_val[m_entry]) end_run(0, 0, 1, seen);
                else if (m_entry == NC - 1) end_run(1, 0, 0, '0);
                else begin
                    m_entry++;
                    m_waiting_done = 0;
                end
            end
            m_elapsed++;
        end else if (start) begin
            m_busy = 1; m_waiting_done = 0; m_done = 0; m_pass = 0; m_to = 0;
            m_entry = 0; m_elapsed = 0; m_fidx = 0; m_fgot = '0;
        end
        if (cfg_we && !was_busy && int'(cfg_idx) < NC) begin
            m_flag[cfg_idx] = cfg_flag;
            m_reg[cfg_idx]  = cfg_reg;
            m_val[cfg_idx]  = cfg_val;
        end
        if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("pass", pass, m_pass);
        check("timed_out", timed_out, m_to);
        check("fail_idx", fail_idx, m_fidx);
        check("fail_got", fail_got, m_fgot);
    endtask

    task automatic idle_inputs();
        wb_en = 0; cfg_we = 0; start = 0;
    endtask

    // Called from a negedge (or time 0); reset is sampled asynchronously
    task automatic apply_reset();
        rst = 0;
        idle_inputs();
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timed_out", timed_out, 0);
        check("rst_fail_idx", fail_idx, 0);
        check("rst_fail_got", fail_got, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    task automatic cfg_write(input int i, input logic [31:0] f, input logic [4:0] r, input logic [31:0] v);
        cfg_we = 1; cfg_idx = 2'(i); cfg_flag = f; cfg_reg = r; cfg_val = v;
        tick();
        cfg_we = 0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic program_basic();
        cfg_write(0, 1, 1, 300);
        cfg_write(1, 2, 1, 500);
        cfg_write(2, 2, 2, 100);
    endtask

    task automatic final_status(input string tag, input bit p, input bit t);
        check({tag, "_done"}, done, 1);
        check({tag, "_pass"}, pass, p);
        check({tag, "_timed_out"}, timed_out, t);
    endtask

    initial begin
        model_reset();
        apply_reset();

        // Flags arrive in order and every value matches
        program_basic();
        pulse_start();
        wb_write(1, 300);  repeat (3) tick();
        wb_write(20, 1);   repeat (1) tick();
        // Table write attempted mid-run must be ignored
        cfg_write(0, 7, 3, 7);
        repeat (1) tick();
        wb_write(1, 500);  repeat (3) tick();
        wb_write(2, 100);  repeat (3) tick();
        wb_write(20, 2);   repeat (8) tick();
        final_status("basic", 1, 0);

        // Mismatch on the last entry reports its index and observed value
        apply_reset();
        program_basic();
        pulse_start();
        wb_write(1, 300);  repeat (3) tick();
        wb_write(20, 1);   repeat (3) tick();
        wb_write(1, 500);  repeat (3) tick();
        wb_write(2, 99);   repeat (3) tick();
        wb_write(20, 2);   repeat (8) tick();
        final_status("mismatch", 0, 0);
        check("mismatch_fail_idx", fail_idx, 2);
        check("mismatch_fail_got", fail_got, 99);

        // Flag never written: timeout exactly TO cycles after start
        apply_reset();
        program_basic();
        pulse_start();
        repeat (TO - 1) tick();
        check("timeout_not_yet", done, 0);
        tick();
        final_status("timeout", 0, 1);
        check("timeout_fail_idx", fail_idx, 0);
        check("timeout_fail_got", fail_got, 0);

        // Final CHECK lands with the counter at the limit
        apply_reset();
        cfg_write(0, 1, 1, 0);
        cfg_write(1, 1, 1, 0);
        cfg_write(2, 2, 1, 0);
        wb_write(20, 1);
        pulse_start();
        repeat (97) tick();
        wb_write(20, 2);
        tick();
        check("limit_busy", busy, 1);
        wb_write(20, 1);
        final_status("limit", 1, 0);

        // Reset during WAIT aborts the run and clears the shadow
        apply_reset();
        program_basic();
        wb_write(1, 300);
        pulse_start();
        repeat (4) tick();
        check("abort_busy_before", busy, 1);
        apply_reset();
        repeat (3) tick();
        check("abort_done", done, 0);
        cfg_write(0, 0, 1, 0);
        cfg_write(1, 0, 1, 0);
        cfg_write(2, 0, 1, 0);
        pulse_start();
        repeat (8) tick();
        final_status("x1_cleared", 1, 0);

        // x0 ignores writes and reads zero; out-of-range table index ignored
        apply_reset();
        cfg_write(0, 0, 0, 0);
        cfg_write(1, 0, 0, 0);
        cfg_write(2, 0, 0, 0);
        cfg_write(3, 5, 0, 5);
        wb_write(0, 32'hDEAD);
        pulse_start();
        repeat (8) tick();
        final_status("x0", 1, 0);

        // Random traffic against the model
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            start  = ($urandom_range(7) == 0);
            wb_en  = $urandom_range(1);
            case ($urandom_range(4))
                0: wb_addr = 0;
                1: wb_addr = 1;
                2: wb_addr = 2;
                3: wb_addr = 5'(FR);
                default: wb_addr = 5'($urandom_range(31));
            endcase
            wb_data  = $urandom_range(2);
            cfg_we   = ($urandom_range(3) == 0);
            cfg_idx  = 2'($urandom_range(3));
            cfg_flag = $urandom_range(2);
            cfg_reg  = ($urandom_range(1) == 0) ? 5'($urandom_range(2)) : 5'(FR);
            cfg_val  = $urandom_range(2);
            tick();
        end
        idle_inputs();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
